// File: rtl/ifu_inst_buffer.sv
// ifu_inst_buffer: in-order instruction queue between fetch and decode.
// Captures {pc, inst} on each fetch response handshake and presents entries
// to decode in the same order. Decode stalls do not block fetch until the
// queue is full. A flush empties the queue in one cycle.
// Optional feature macro: IBUF_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty and decode is ready goes straight to decode
// in the same cycle.
module ifu_inst_buffer #(
  parameter  int DEPTH  = 4,
  parameter  int PC_W   = 32,
  parameter  int INST_W = 32,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [PC_W-1:0]   id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int IDX_W = CNT_W - 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

  ibuf_entry_t             mem [DEPTH];
  logic [CNT_W-1:0]        rd_ptr, wr_ptr, count_q;
  logic                    empty, full;
  logic                    push, pop, bypass;
  ibuf_entry_t             head;

  // The pointers carry one extra wrap bit so that full and empty are distinct.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                 (rd_ptr[CNT_W-1]   != wr_ptr[CNT_W-1]);

  assign head = mem[rd_ptr[IDX_W-1:0]];

`ifdef IBUF_BYPASS_EN
  // Empty queue with decode ready: the response is handed over directly and
  // is never written into storage.
  assign bypass     = empty && in_valid_i && id_ready_i && !flush_i;
  assign id_valid_o = !flush_i && (!empty || bypass);
  assign id_pc_o    = bypass ? in_pc_i   : head.pc;
  assign id_inst_o  = bypass ? in_inst_i : head.inst;
`else
  // Without the bypass, decode sees only registered storage. No combinational
  // path runs from in_* to id_*.
  assign bypass     = 1'b0;
  assign id_valid_o = !empty && !flush_i;
  assign id_pc_o    = head.pc;
  assign id_inst_o  = head.inst;
`endif

  // Ready depends only on registered occupancy. A pop in the same cycle does
  // not make room when the queue is full.
  assign in_ready_o = !full;

  assign push = in_valid_i && in_ready_o && !flush_i && !bypass;
  assign pop  = !empty && id_ready_i && !flush_i;

  assign count_o = count_q;

  // Storage write at the tail. The entries are not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= '{pc: in_pc_i, inst: in_inst_i};
  end

  // Pointer and occupancy update. Reset takes priority over flush, and flush
  // takes priority over the handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Self-checking bench for ifu_inst_buffer. The reference is a plain FIFO
// queue of {pc, inst}. The bench runs directed scenarios first and then
// randomized traffic with occasional flushes and resets.
module tb_ifu_inst_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i, flush_i;
  logic [31:0]      in_pc_i, in_inst_i;
  logic             in_valid_i, in_ready_o;
  logic [31:0]      id_pc_o, id_inst_o;
  logic             id_valid_o, id_ready_i;
  logic [CNT_W-1:0] count_o;

  ifu_inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] mq[$];
  logic        stalled;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the outputs against the queue model,
  // and then applies the model's update at the clock edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] inst,
                      input logic ir);
    int          n;
    logic        byp, exp_v;
    logic [63:0] head;
    rst_i = rst; flush_i = fl; in_valid_i = iv;
    in_pc_i = pc; in_inst_i = inst; id_ready_i = ir;
    #2;
    n   = mq.size();
    byp = 1'b0;
`ifdef IBUF_BYPASS_EN
    byp = (n == 0) && iv && ir && !fl;
`endif
    exp_v = !fl && (n > 0 || byp);
    head  = byp ? {pc, inst} : ((n > 0) ? mq[0] : 64'h0);
    chk("count", 64'(count_o), 64'(n));
    chk("in_ready", 64'(in_ready_o), 64'(n < DEPTH));
    chk("id_valid", 64'(id_valid_o), 64'(exp_v));
    if (exp_v) begin
      chk("id_pc", 64'(id_pc_o), 64'(head[63:32]));
      chk("id_inst", 64'(id_inst_o), 64'(head[31:0]));
    end
    stalled = iv && (n >= DEPTH);
    @(posedge clk_i); #1;
    if (rst || fl) mq.delete();
    else begin
      if (exp_v && ir && !byp) void'(mq.pop_front());
      if (iv && n < DEPTH && !byp) mq.push_back({pc, inst});
    end
  endtask

  task automatic idle(input logic ir);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ir);
  endtask

  initial begin
    logic        hv;
    logic [31:0] hpc, hinst;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; id_ready_i = 1'b0;
    in_pc_i = '0; in_inst_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    idle(1'b0);                                       // reset state

    // Reset while traffic is in flight at occupancy 3.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h7000_0000 + 32'(i*4), 32'h33 + 32'(i), 0);
    step(1, 0, 1, 32'h7000_00F0, 32'hAA, 1);
    step(1, 0, 1, 32'h7000_00F4, 32'hBB, 1);
    idle(1'b0);

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h8000_0000 + 32'(i*4), 32'h13 + 32'(i*32'h80), 0);
    step(0, 0, 1, 32'h8000_0010, 32'h213, 0);         // full: offer not taken
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Streaming with both sides ready; the pointers wrap several times.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'h8000_0100 + 32'(i*4), 32'h100 + 32'(i), 1);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Flush at occupancy 3 with a push offered in the same cycle.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h8000_0200 + 32'(i*4), 32'h200 + 32'(i), 0);
    step(0, 1, 1, 32'h8000_0DEC, 32'hDEC, 1);
    step(0, 0, 1, 32'h8000_1000, 32'h1000, 0);
    idle(1'b1);
    idle(1'b1);

    // Pop at full with a push offered: the push is refused, then lands at the tail.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h8000_0300 + 32'(i*4), 32'h300 + 32'(i), 0);
    step(0, 0, 1, 32'h8000_0310, 32'h310, 1);
    step(0, 0, 1, 32'h8000_0310, 32'h310, 0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Push into an empty queue with decode ready.
    step(0, 0, 1, 32'h8000_0040, 32'h40, 1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic. A refused offer is held stable on the next cycle.
    hv = 1'b0; hpc = '0; hinst = '0;
    for (int c = 0; c < 600; c++) begin
      logic r, f, ir;
      r  = ($urandom_range(0, 79) == 0);
      f  = ($urandom_range(0, 19) == 0);
      ir = ($urandom_range(0, 2) != 0);
      if (!stalled) begin
        hv    = ($urandom_range(0, 3) != 0);
        hpc   = $urandom;
        hinst = $urandom;
      end
      step(r, f, hv, hpc, hinst, ir);
    end
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary by %0t", $time);
    $fatal(1);
  end

endmodule
